// File: rtl/scan_decoder.sv
// One-hot select decoder with direct and auto-scan modes.
// Scan dwells DIV cycles per index and pulses oWrap on wrap-around.
module scan_decoder #(
    parameter int N   = 3,
    parameter int DIV = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [N-1:0]        iData,
    input  logic [1:0]          iEna,
    input  logic                iMode,
    input  logic                iHold,
    output logic [(1<<N)-1:0]   oData,
    output logic [N-1:0]        oIndex,
    output logic                oWrap
);

    localparam int W  = 1 << N;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
    localparam logic [N-1:0]  ILAST = '1;

    logic [N-1:0]  index;
    logic [N-1:0]  indexNext;
    logic [PW-1:0] presc;
    logic [PW-1:0] prescNext;
    logic          enaReg;
    logic          prevMode;
    logic          armed;
    logic          scanActive;
    logic          scanActiveNext;
    logic          wrapNext;
    logic [W-1:0]  dataNext;
    logic          enNow;
    logic          scanEntry;
    logic          step;
    logic          stepLast;
    logic          stepMid;

    // armed: iMode has been seen low since reset, so a rising edge is genuine
    always_comb begin
        enNow          = (iEna == 2'b10);
        scanEntry      = iMode && !prevMode && armed;
        step           = iMode && scanActive && enNow && !iHold;
        stepLast       = step && (presc == PLAST);
        stepMid        = step && (presc != PLAST);
        indexNext      = index;
        prescNext      = presc;
        scanActiveNext = scanActive;
        wrapNext       = 1'b0;
        unique case (1'b1)
            !iMode: begin
                indexNext      = iData;
                prescNext      = '0;
                scanActiveNext = 1'b0;
            end
            scanEntry: begin
                indexNext      = iData;
                prescNext      = '0;
                scanActiveNext = 1'b1;
            end
            stepLast: begin
                indexNext = index + 1'b1;
                prescNext = '0;
                wrapNext  = (index == ILAST);
            end
            stepMid: begin
                prescNext = presc + 1'b1;
            end
            default: ;
        endcase
        dataNext = '0;
        if (enNow) begin
            dataNext[indexNext] = 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            index      <= '0;
            presc      <= '0;
            enaReg     <= 1'b0;
            prevMode   <= 1'b0;
            armed      <= 1'b0;
            scanActive <= 1'b0;
            oData      <= '0;
            oWrap      <= 1'b0;
        end else begin
            index      <= indexNext;
            presc      <= prescNext;
            enaReg     <= enNow;
            prevMode   <= iMode;
            armed      <= armed | !iMode;
            scanActive <= scanActiveNext;
            oData      <= dataNext;
            oWrap      <= wrapNext;
        end
    end

    assign oIndex = index;

    // enaReg mirrors the gating already folded into oData
    logic unusedEna;
    assign unusedEna = enaReg;

endmodule
